// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, steps it through a run from an
// accepted start to a halt, applies taken-branch offsets returned by an
// external combinational lookup table, and counts RUN cycles.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start after reset; pc/cycles/done at reset values
//  RUN   | fetching; pc advances by +1, by the branch offset, or holds
//  DONE  | run halted; done=1, pc and cycles frozen until the next start
module pc_sequencer #(
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          branch,
    input  logic          taken,
    input  logic [5:0]    branch_idx,
    input  logic          halt,
    output logic [5:0]    lut_addr,
    input  logic [D-1:0]  lut_target,
    output logic [D-1:0]  pc,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    // The table index is a plain pass-through so branch resolution adds no latency.
    assign lut_addr = branch_idx;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection and the fetch qualifier.
    always_comb begin
        state_next  = state;
        fetch_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (halt) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // PC, cycle counter and done flag; halt outranks stall, which outranks a taken branch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc     <= '0;
            cycles <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pc     <= start_addr;
                        cycles <= '0;
                        done   <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycles != {CW{1'b1}}) cycles <= cycles + 1'b1;
                    if (halt) begin
                        done <= 1'b1;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (branch && taken) begin
                        pc <= pc + lut_target;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the single-issue core. Owns the PC register and sequences instruction fetch from a start handshake to a halt. It resolves taken branches by driving the 6-bit index into the branch-target lookup table and adding the returned signed offset to the PC. It also reports run length and completion to the testbench/top level.

Parameters:
D, 12, PC width in bits; also the width of the lookup-table target.
CW, 16, width of the cycle counter.

Ports:
Clk  input  1  system clock; all state updates on its rising edge.
Reset  input  1  synchronous, active-high reset.
start  input  1  begin a program run; sampled only in IDLE or DONE.
start_addr  input  D  first PC of the run, latched on an accepted start.
stall  input  1  freeze the PC for this cycle (RUN only).
branch  input  1  current instruction is a conditional branch.
taken  input  1  branch condition is true; meaningful only when branch=1.
branch_idx  input  6  lookup-table index from the instruction field.
halt  input  1  current instruction is a halt.
lut_addr  output  6  index to the lookup table; combinational copy of branch_idx.
lut_target  input  D  signed PC offset returned by the lookup table.
pc  output  D  current PC / instruction-memory address.
fetch_valid  output  1  high when pc addresses a live instruction (state RUN).
done  output  1  run finished; held until the next accepted start.
cycles  output  CW  RUN cycles of the last or current run.

Behaviour:
- States are IDLE, RUN and DONE, encoded in 2 bits.
- Reset values (synchronous, Reset=1 at edge): state=IDLE, pc=0, done=0, cycles=0. fetch_valid=0 follows from the state.
- Reset has priority over every other input, including mid-RUN. The PC does not survive reset.
- IDLE:
  - start=1 → RUN next cycle; pc<=start_addr, cycles<=0, done<=0.
  - Otherwise hold.
- RUN: fetch_valid=1. Per-edge priority, highest first:
  1. halt=1 → DONE; pc holds; done<=1. cycles increments for this cycle.
  2. stall=1 → pc holds; cycles increments.
  3. branch=1 & taken=1 → pc <= pc + lut_target.
  4. Otherwise pc <= pc + 1.
- Branch arithmetic:
  - lut_target is treated as two's-complement D-bit. The add is modulo 2^D (wraps, no saturation, no error).
  - A target of 0 (the table default) is a legal "hold PC" branch; the PC stays put while taken stays high.
  - branch=1 with taken=0 behaves as a plain increment.
- Increment wraps: pc = 2^D−1 → 0.
- Branch resolution is zero-latency. lut_addr is combinational from branch_idx, the table is combinational, and the new PC appears the cycle after the branch is presented. There are no bubbles and no delay slots.
- start is ignored in RUN.
- DONE:
  - done=1, fetch_valid=0, pc and cycles hold.
  - start=1 → RUN as from IDLE, with done cleared on the same edge.
- cycles counts every edge spent in RUN, including stall and halt cycles. It saturates at 2^CW−1.
- halt, stall, branch and taken are don't-care outside RUN.
- lut_addr always reflects branch_idx, in every state.

Test Plan:
1. Straight-line run: Reset, then start with start_addr=0. After 3 RUN edges pc=3. Halt on the next edge → done=1, pc=3, cycles=4, fetch_valid=0.
2. Forward and backward branches: run from 0, with the table returning +14 for index 16 and −143 (12'hF71) for index 17. A taken branch at pc=5 with idx16 → pc=19. A taken branch at pc=200 with idx17 → pc=57.
3. Priority and hold:
   - At pc=8, assert stall+branch+taken → pc stays 8.
   - Next cycle, assert halt+branch+taken → DONE with pc=8.
   - branch=1, taken=0 at pc=9 → pc=10.
   - Taken branch to a default index (target 0) → pc unchanged.
4. Wrap: start_addr=12'hFFF, one increment → pc=0. A taken branch at pc=2 with offset −3 → pc=12'hFFF.
5. Reset mid-run: at pc=40 with cycles=25, assert Reset for one edge → state=IDLE, pc=0, cycles=0, done=0. start during that Reset edge is ignored.
6. Restart from DONE: after a run ends, start with start_addr=100 → done falls on the same edge, pc=100, cycles=0. A start pulse during RUN has no effect on pc.
